// File: rtl/vga_timing_gen_pkg.sv
// rtl/vga_timing_gen_pkg.sv - shared types, timing presets and width helpers for the VGA timing generator
// Contents:
//   vga_axis_t / vga_timing_t : active/front-porch/sync/back-porch per axis
//   VGA_640x480_60            : default 640x480@60 timing
//   vga_ctl_t                 : de/hs/vs activity flags carried down the delay pipe
//   rgb_t                     : widest {r,g,b} triple
//   cnt_w / axis_total        : counter width and line/frame length helpers
package vga_timing_gen_pkg;

  typedef struct packed {
    logic [15:0] active;
    logic [15:0] fp;
    logic [15:0] sync;
    logic [15:0] bp;
  } vga_axis_t;

  typedef struct packed {
    vga_axis_t h;
    vga_axis_t v;
  } vga_timing_t;

  localparam vga_timing_t VGA_640x480_60 = '{
    h: '{active: 16'd640, fp: 16'd16, sync: 16'd96, bp: 16'd48},
    v: '{active: 16'd480, fp: 16'd10, sync: 16'd2,  bp: 16'd33}
  };

  // Flags are carried as "active" (polarity-free); polarity is applied at the pins.
  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
  } vga_ctl_t;

  localparam int MAX_COLOR_W = 8;

  typedef struct packed {
    logic [MAX_COLOR_W-1:0] r;
    logic [MAX_COLOR_W-1:0] g;
    logic [MAX_COLOR_W-1:0] b;
  } rgb_t;

  function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int cnt_w(input int total);
    return (total <= 2) ? 1 : $clog2(total);
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - pixel request / colour / VGA pin bundle between line buffer, generator and pins
// Signals: color_in {r,g,b}; pix_x, pix_y, pix_req (undelayed coordinates); vga_r/g/b, vga_hs,
//   vga_vs, vga_de (registered pins); next_line, frame_start (undelayed pulses).
// Modports: master = timing generator, slave = pixel source / pin consumer.
interface vga_timing_gen_if #(
  parameter int X_W     = 10,
  parameter int Y_W     = 10,
  parameter int COLOR_W = 4
);
  logic [3*COLOR_W-1:0] color_in;
  logic [X_W-1:0]       pix_x;
  logic [Y_W-1:0]       pix_y;
  logic                 pix_req;
  logic [COLOR_W-1:0]   vga_r;
  logic [COLOR_W-1:0]   vga_g;
  logic [COLOR_W-1:0]   vga_b;
  logic                 vga_hs;
  logic                 vga_vs;
  logic                 vga_de;
  logic                 next_line;
  logic                 frame_start;

  modport master (
    input  color_in,
    output pix_x, pix_y, pix_req, vga_r, vga_g, vga_b,
           vga_hs, vga_vs, vga_de, next_line, frame_start
  );

  modport slave (
    output color_in,
    input  pix_x, pix_y, pix_req, vga_r, vga_g, vga_b,
           vga_hs, vga_vs, vga_de, next_line, frame_start
  );
endinterface

// File: rtl/vga_timing_gen_axis_counter.sv
// rtl/vga_timing_gen_axis_counter.sv - one raster axis: wrapping position counter plus region flags
// Ports: clk, rst (sync active-high), en (advance one position);
//   cnt (position), last (cnt==TOTAL-1), active (cnt<ACTIVE), sync (inside sync pulse),
//   next_active (the position after this one, modulo TOTAL, is visible).
module vga_timing_gen_axis_counter
  import vga_timing_gen_pkg::*;
#(
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int BP     = 48,
  parameter int W      = cnt_w(axis_total(ACTIVE, FP, SYNC, BP))
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         last,
  output logic         active,
  output logic         sync,
  output logic         next_active
);
  localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);
  localparam logic [W-1:0] LAST_C  = W'(TOTAL - 1);
  localparam logic [W-1:0] ACT_C   = W'(ACTIVE);
  localparam logic [W-1:0] SYNC_LO = W'(ACTIVE + FP);
  localparam logic [W-1:0] SYNC_HI = W'(ACTIVE + FP + SYNC);
  localparam logic [W-1:0] ONE     = W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= last ? '0 : cnt + ONE;
    end
  end

  assign last   = (cnt == LAST_C);
  assign active = (cnt < ACT_C);
  assign sync   = (cnt >= SYNC_LO) && (cnt < SYNC_HI);
  // On the last position the successor is 0, which is always visible (ACTIVE>0);
  // otherwise cnt+1 cannot overflow because cnt < TOTAL-1.
  assign next_active = last ? 1'b1 : ((cnt + ONE) < ACT_C);
endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA raster/timing generator with delayed sync/de/rgb outputs
// Ports: CLK25MHZ (pixel clock), ck_rst (sync active-high reset), bus (vga_timing_gen_if.master):
//   color_in in; pix_x/pix_y/pix_req, next_line, frame_start undelayed; vga_r/g/b/hs/vs/de
//   registered and mutually aligned, PIPE_LAT+1 cycles after the matching pix_x/pix_y.
// Build option: define VGA_TEST_PATTERN_EN to replace color_in by 8 vertical colour bars.
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int H_ACTIVE = int'(VGA_640x480_60.h.active),
  parameter int H_FP     = int'(VGA_640x480_60.h.fp),
  parameter int H_SYNC   = int'(VGA_640x480_60.h.sync),
  parameter int H_BP     = int'(VGA_640x480_60.h.bp),
  parameter int V_ACTIVE = int'(VGA_640x480_60.v.active),
  parameter int V_FP     = int'(VGA_640x480_60.v.fp),
  parameter int V_SYNC   = int'(VGA_640x480_60.v.sync),
  parameter int V_BP     = int'(VGA_640x480_60.v.bp),
  parameter int COLOR_W  = 4,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int PIPE_LAT = 1
) (
  input logic             CLK25MHZ,
  input logic             ck_rst,
  vga_timing_gen_if.master bus
);
  localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int X_W     = cnt_w(H_TOTAL);
  localparam int Y_W     = cnt_w(V_TOTAL);
  localparam int SR_N    = (PIPE_LAT > 0) ? PIPE_LAT : 1;

  generate
    if (H_ACTIVE <= 0 || H_FP <= 0 || H_SYNC <= 0 || H_BP <= 0 ||
        V_ACTIVE <= 0 || V_FP <= 0 || V_SYNC <= 0 || V_BP <= 0) begin : g_bad_timing
      $error("vga_timing_gen: every timing parameter must be > 0");
    end
    if (PIPE_LAT < 0 || PIPE_LAT > 4) begin : g_bad_lat
      $error("vga_timing_gen: PIPE_LAT must be 0..4");
    end
    if (COLOR_W < 1 || COLOR_W > 8) begin : g_bad_color
      $error("vga_timing_gen: COLOR_W must be 1..8");
    end
  endgenerate

  logic [X_W-1:0] h_cnt;
  logic [Y_W-1:0] v_cnt;
  logic h_last, h_act, h_sync, h_next_act;
  logic v_last, v_act, v_sync, v_next_act;

  vga_timing_gen_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .W(X_W)
  ) u_h_cnt (
    .clk(CLK25MHZ), .rst(ck_rst), .en(1'b1),
    .cnt(h_cnt), .last(h_last), .active(h_act), .sync(h_sync), .next_active(h_next_act)
  );

  // The vertical axis advances once per line, on the horizontal wrap.
  vga_timing_gen_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .W(Y_W)
  ) u_v_cnt (
    .clk(CLK25MHZ), .rst(ck_rst), .en(h_last),
    .cnt(v_cnt), .last(v_last), .active(v_act), .sync(v_sync), .next_active(v_next_act)
  );

  assign bus.pix_x   = h_cnt;
  assign bus.pix_y   = v_cnt;
  assign bus.pix_req = h_act & v_act;

  // Pulses are masked while reset is held so the first one appears on the first free cycle.
  assign bus.frame_start = (h_cnt == '0) && (v_cnt == '0) && !ck_rst;
  assign bus.next_line   = (h_cnt == X_W'(H_ACTIVE)) && v_next_act && !ck_rst;

  vga_ctl_t ctl_raw;
  vga_ctl_t ctl_d;
  assign ctl_raw = '{de: h_act & v_act, hs: h_sync, vs: v_sync};

`ifdef VGA_TEST_PATTERN_EN
  // Bar index travels with the control flags so the pattern keeps the same alignment.
  localparam int PW = 6;
  logic [31:0]          bar_full;
  logic [2:0]           bar_d;
  logic [3*COLOR_W-1:0] rgb_src;
  logic [PW-1:0]        stage_in;
  logic                 unused_pattern;
  assign bar_full = (32'(h_cnt) * 32'd8) / 32'(H_ACTIVE);
  assign stage_in = {ctl_raw, bar_full[2:0]};
  assign rgb_src  = {{COLOR_W{bar_d[2]}}, {COLOR_W{bar_d[1]}}, {COLOR_W{bar_d[0]}}};
  assign unused_pattern = ^{bar_full[31:3], bus.color_in};
`else
  localparam int PW = 3;
  logic [3*COLOR_W-1:0] rgb_src;
  logic [PW-1:0]        stage_in;
  assign stage_in = ctl_raw;
  assign rgb_src  = bus.color_in;
`endif

  logic [PW-1:0] sr [SR_N];
  logic [PW-1:0] stage_out;

  // All-zero entries mean "blank, no sync", so a flushed pipe emits idle timing.
  always_ff @(posedge CLK25MHZ) begin
    if (ck_rst) begin
      for (int i = 0; i < SR_N; i++) sr[i] <= '0;
    end else begin
      sr[0] <= stage_in;
      for (int i = 1; i < SR_N; i++) sr[i] <= sr[i-1];
    end
  end

  assign stage_out = (PIPE_LAT == 0) ? stage_in : sr[SR_N-1];
  assign ctl_d     = vga_ctl_t'(stage_out[PW-1 -: 3]);
`ifdef VGA_TEST_PATTERN_EN
  assign bar_d     = stage_out[2:0];
`endif

  always_ff @(posedge CLK25MHZ) begin
    if (ck_rst) begin
      {bus.vga_r, bus.vga_g, bus.vga_b} <= '0;
      bus.vga_de <= 1'b0;
      bus.vga_hs <= ~HS_POL;
      bus.vga_vs <= ~VS_POL;
    end else begin
      {bus.vga_r, bus.vga_g, bus.vga_b} <= ctl_d.de ? rgb_src : '0;
      bus.vga_de <= ctl_d.de;
      bus.vga_hs <= ctl_d.hs ? HS_POL : ~HS_POL;
      bus.vga_vs <= ctl_d.vs ? VS_POL : ~VS_POL;
    end
  end

  logic unused_flags;
  assign unused_flags = ^{h_next_act, v_last};
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed bench for vga_timing_gen on a 16x8 raster
module tb_vga_timing_gen;
  logic clk = 1'b0;
  logic ck_rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  int   n = 0;

  always #20 clk = ~clk;

  vga_timing_gen_if #(.X_W(4), .Y_W(3), .COLOR_W(4)) bus ();

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .COLOR_W(4), .HS_POL(1'b0), .VS_POL(1'b0), .PIPE_LAT(1)
  ) dut (
    .CLK25MHZ(clk),
    .ck_rst(ck_rst),
    .bus(bus)
  );

  function automatic int hh(int k); return k % 16; endfunction
  function automatic int vv(int k); return (k / 16) % 8; endfunction

  function automatic logic [11:0] src_rgb(int x);
    logic [3:0] xv;
    xv = x[3:0];
    return 12'hA5C ^ {xv, xv, xv};
  endfunction

  function automatic logic [11:0] exp_rgb(int x);
    logic [3:0] xv;
    xv = x[3:0];
`ifdef VGA_TEST_PATTERN_EN
    return {{4{xv[2]}}, {4{xv[1]}}, {4{xv[0]}}};
`else
    return 12'hA5C ^ {xv, xv, xv};
`endif
  endfunction

  function automatic logic exp_de(int k); return (k >= 0) && hh(k) < 8 && vv(k) < 4; endfunction
  function automatic logic exp_hs(int k); return !((k >= 0) && hh(k) >= 10 && hh(k) < 13); endfunction
  function automatic logic exp_vs(int k); return !((k >= 0) && vv(k) >= 5 && vv(k) < 7); endfunction
  function automatic logic exp_nl(int k); return hh(k) == 8 && ((vv(k) + 1) % 8) < 4; endfunction

  // One pixel clock: color_in tracks the coordinate of the previous cycle (PIPE_LAT=1).
  task automatic cyc();
    @(posedge clk);
    #1;
    n++;
    bus.color_in = src_rgb(hh(n - 1));
    @(negedge clk);
  endtask

  task automatic test_reset();
    bus.color_in = 12'hFFF;
    ck_rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      vectors++;
      if ({bus.vga_hs, bus.vga_vs, bus.vga_de, bus.vga_r, bus.vga_g, bus.vga_b} !== {3'b110, 12'h000}) begin
        miscompares++;
        $display("FAIL reset_outputs cyc=%0d got hs/vs/de/rgb=%b%b%b/%h want 110/000", i,
                 bus.vga_hs, bus.vga_vs, bus.vga_de, {bus.vga_r, bus.vga_g, bus.vga_b});
      end
      vectors++;
      if ({bus.frame_start, bus.next_line} !== 2'b00) begin
        miscompares++;
        $display("FAIL reset_pulses cyc=%0d got fs/nl=%b%b want 00", i, bus.frame_start, bus.next_line);
      end
    end
    ck_rst = 1'b0;
    n = 0;
    #1;
    vectors++;
    if ({bus.pix_x, bus.pix_y, bus.frame_start, bus.pix_req} !== {4'd0, 3'd0, 1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL release_first got x=%0d y=%0d fs=%b req=%b want 0 0 1 1",
               bus.pix_x, bus.pix_y, bus.frame_start, bus.pix_req);
    end
  endtask

  task automatic test_frame_timing();
    int hs_low;
    int vs_low;
    hs_low = 0;
    vs_low = 0;
    for (int i = 0; i < 128; i++) begin
      cyc();
      vectors++;
      if ({bus.pix_x, bus.pix_y} !== {4'(hh(n)), 3'(vv(n))}) begin
        miscompares++;
        $display("FAIL counters n=%0d got x=%0d y=%0d want %0d %0d", n, bus.pix_x, bus.pix_y, hh(n), vv(n));
      end
      vectors++;
      if (bus.frame_start !== (n % 128 == 0)) begin
        miscompares++;
        $display("FAIL frame_start n=%0d got %b want %b", n, bus.frame_start, (n % 128 == 0));
      end
      vectors++;
      if ({bus.vga_hs, bus.vga_vs} !== {exp_hs(n - 2), exp_vs(n - 2)}) begin
        miscompares++;
        $display("FAIL syncs n=%0d got hs=%b vs=%b want %b %b", n, bus.vga_hs, bus.vga_vs,
                 exp_hs(n - 2), exp_vs(n - 2));
      end
      if (bus.vga_hs === 1'b0) hs_low++;
      if (bus.vga_vs === 1'b0) vs_low++;
    end
    vectors++;
    if (hs_low != 24) begin
      miscompares++;
      $display("FAIL hs_low_total got %0d want 24", hs_low);
    end
    vectors++;
    if (vs_low != 32) begin
      miscompares++;
      $display("FAIL vs_low_total got %0d want 32", vs_low);
    end
  endtask

  task automatic test_color();
    int de_cnt;
    logic [11:0] want;
    de_cnt = 0;
    for (int i = 0; i < 128; i++) begin
      cyc();
      want = exp_de(n - 2) ? exp_rgb(hh(n - 2)) : 12'h000;
      vectors++;
      if (bus.vga_de !== exp_de(n - 2)) begin
        miscompares++;
        $display("FAIL de n=%0d got %b want %b", n, bus.vga_de, exp_de(n - 2));
      end
      vectors++;
      if ({bus.vga_r, bus.vga_g, bus.vga_b} !== want) begin
        miscompares++;
        $display("FAIL rgb n=%0d got %h want %h", n, {bus.vga_r, bus.vga_g, bus.vga_b}, want);
      end
      vectors++;
      if (bus.pix_req !== exp_de(n)) begin
        miscompares++;
        $display("FAIL pix_req n=%0d got %b want %b", n, bus.pix_req, exp_de(n));
      end
      if (bus.vga_de === 1'b1) de_cnt++;
    end
    vectors++;
    if (de_cnt != 32) begin
      miscompares++;
      $display("FAIL de_total got %0d want 32", de_cnt);
    end
  endtask

  task automatic test_next_line();
    int pulses;
    logic [7:0] lines;
    pulses = 0;
    lines = 8'h00;
    for (int i = 0; i < 128; i++) begin
      cyc();
      vectors++;
      if (bus.next_line !== exp_nl(n)) begin
        miscompares++;
        $display("FAIL next_line n=%0d got %b want %b", n, bus.next_line, exp_nl(n));
      end
      if (bus.next_line === 1'b1) begin
        pulses++;
        lines[vv(n)] = 1'b1;
      end
    end
    vectors++;
    if (pulses != 4) begin
      miscompares++;
      $display("FAIL next_line_count got %0d want 4", pulses);
    end
    vectors++;
    if (lines !== 8'b1000_0111) begin
      miscompares++;
      $display("FAIL next_line_lines got %b want 10000111", lines);
    end
  endtask

  task automatic test_mid_reset();
    // Advance to h=5, v=2 (a visible pixel with live data in the pipe).
    for (int i = 0; i < 200 && (n % 128) != 37; i++) cyc();
    vectors++;
    if ({bus.pix_x, bus.pix_y} !== {4'd5, 3'd2}) begin
      miscompares++;
      $display("FAIL mid_reset_pos got x=%0d y=%0d want 5 2", bus.pix_x, bus.pix_y);
    end
    ck_rst = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    vectors++;
    if ({bus.vga_hs, bus.vga_vs, bus.vga_de, bus.vga_r, bus.vga_g, bus.vga_b} !== {3'b110, 12'h000}) begin
      miscompares++;
      $display("FAIL mid_reset_outputs got hs/vs/de/rgb=%b%b%b/%h want 110/000",
               bus.vga_hs, bus.vga_vs, bus.vga_de, {bus.vga_r, bus.vga_g, bus.vga_b});
    end
    vectors++;
    if ({bus.pix_x, bus.pix_y, bus.frame_start, bus.next_line} !== {4'd0, 3'd0, 2'b00}) begin
      miscompares++;
      $display("FAIL mid_reset_counters got x=%0d y=%0d fs=%b nl=%b want 0 0 0 0",
               bus.pix_x, bus.pix_y, bus.frame_start, bus.next_line);
    end
    ck_rst = 1'b0;
    n = 0;
    #1;
    vectors++;
    if (bus.frame_start !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_reset_frame_start got %b want 1", bus.frame_start);
    end
    for (int i = 0; i < 6; i++) begin
      cyc();
      vectors++;
      if ({bus.pix_x, bus.vga_de, bus.vga_r, bus.vga_g, bus.vga_b} !==
          {4'(hh(n)), exp_de(n - 2), (exp_de(n - 2) ? exp_rgb(hh(n - 2)) : 12'h000)}) begin
        miscompares++;
        $display("FAIL mid_reset_restart n=%0d got x=%0d de=%b rgb=%h want x=%0d de=%b",
                 n, bus.pix_x, bus.vga_de, {bus.vga_r, bus.vga_g, bus.vga_b}, hh(n), exp_de(n - 2));
      end
    end
  endtask

  initial begin
    bus.color_in = 12'h000;
    test_reset();
    test_frame_timing();
    test_color();
    test_next_line();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
